// File: rtl/io_responder_pkg.sv
// Shared types and constants for the I/O-space responder: address map,
// STATUS bit positions and the packed STATUS layout.
package io_responder_pkg;

  localparam int DATA_W = 16;

  localparam logic [1:0] IO_ADDR_TX     = 2'd0;
  localparam logic [1:0] IO_ADDR_RX     = 2'd1;
  localparam logic [1:0] IO_ADDR_STATUS = 2'd2;
  localparam logic [1:0] IO_ADDR_RSVD   = 2'd3;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_FULL  = 2;
  localparam int ST_RX_EMPTY = 3;
  localparam int ST_TX_CNT_LO = 4;
  localparam int ST_RX_CNT_LO = 7;
  localparam int ST_TX_OVF   = 10;
  localparam int ST_RX_UDF   = 11;

  // Field order is MSB first so the struct maps directly onto the STATUS word.
  typedef struct packed {
    logic [3:0] rsvd;
    logic       rx_udf;
    logic       tx_ovf;
    logic [2:0] rx_count;
    logic [2:0] tx_count;
    logic       rx_empty;
    logic       rx_full;
    logic       tx_empty;
    logic       tx_full;
  } io_status_t;

endpackage

// File: rtl/io_responder_if.sv
// CPU-side iom bus plus the TX/RX valid/ready streams of the I/O responder.
interface io_responder_if;
  import io_responder_pkg::*;

  logic              iom_in;
  logic              wen_in;
  logic [15:0]       addr_in;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;

  logic              tx_valid_out;
  logic [DATA_W-1:0] tx_data_out;
  logic              tx_ready_in;

  logic              rx_valid_in;
  logic [DATA_W-1:0] rx_data_in;
  logic              rx_ready_out;

  modport master (
    output iom_in, wen_in, addr_in, data_in, tx_ready_in, rx_valid_in, rx_data_in,
    input  data_out, tx_valid_out, tx_data_out, rx_ready_out
  );

  modport slave (
    input  iom_in, wen_in, addr_in, data_in, tx_ready_in, rx_valid_in, rx_data_in,
    output data_out, tx_valid_out, tx_data_out, rx_ready_out
  );

endinterface

// File: rtl/io_fifo.sv
// Synchronous FIFO used for both responder directions; push/pop are
// self-qualified against the pre-edge full/empty state.
module io_fifo
  import io_responder_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_head,
  output logic              o_full,
  output logic              o_empty,
  output logic [CNT_W-1:0]  o_count
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_push;
  logic              w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  // Storage is left unreset, so an empty FIFO presents zero instead of stale data.
  assign o_head = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

endmodule

// File: rtl/io_responder.sv
// I/O-space responder: address decode, combinational read mux and error flags.
// Optional sticky tx_ovf/rx_udf flags are built when IORESP_ERR_FLAGS_EN is defined.
module io_responder
  import io_responder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  io_responder_if.slave  bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  function automatic logic [2:0] sat_cnt(input logic [CNT_W-1:0] c);
    if (32'(c) > 32'd7) return 3'd7;
    return 3'(c);
  endfunction

  logic [1:0]        w_sel;
  logic              w_wr;
  logic              w_rd;
  logic              w_tx_push;
  logic              w_rx_pop;
  logic              w_stat_rd;
  logic              w_unused_addr;

  logic [DATA_W-1:0] w_tx_head;
  logic              w_tx_full;
  logic              w_tx_empty;
  logic [CNT_W-1:0]  w_tx_count;
  logic [DATA_W-1:0] w_rx_head;
  logic              w_rx_full;
  logic              w_rx_empty;
  logic [CNT_W-1:0]  w_rx_count;

  logic              w_tx_ovf;
  logic              w_rx_udf;
  io_status_t        w_status;
  logic [DATA_W-1:0] w_rdata;

  assign w_sel         = bus.addr_in[1:0];
  assign w_unused_addr = ^bus.addr_in[15:2];
  assign w_wr          = bus.iom_in & ~bus.wen_in;
  assign w_rd          = bus.iom_in & bus.wen_in;
  assign w_tx_push     = w_wr && (w_sel == IO_ADDR_TX);
  assign w_rx_pop      = w_rd && (w_sel == IO_ADDR_RX);
  assign w_stat_rd     = w_rd && (w_sel == IO_ADDR_STATUS);

  io_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_tx_push),
    .i_push_data (bus.data_in),
    .i_pop       (bus.tx_ready_in),
    .o_head      (w_tx_head),
    .o_full      (w_tx_full),
    .o_empty     (w_tx_empty),
    .o_count     (w_tx_count)
  );

  io_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (bus.rx_valid_in),
    .i_push_data (bus.rx_data_in),
    .i_pop       (w_rx_pop),
    .o_head      (w_rx_head),
    .o_full      (w_rx_full),
    .o_empty     (w_rx_empty),
    .o_count     (w_rx_count)
  );

  assign bus.tx_valid_out = ~w_tx_empty;
  assign bus.tx_data_out  = w_tx_head;
  assign bus.rx_ready_out = ~w_rx_full;

`ifdef IORESP_ERR_FLAGS_EN
  logic r_tx_ovf;
  logic r_rx_udf;
  logic w_tx_drop;
  logic w_rx_miss;

  assign w_tx_drop = w_tx_push & w_tx_full;
  assign w_rx_miss = w_rx_pop & w_rx_empty;

  // A new error in the clearing cycle wins over the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_ovf <= 1'b0;
      r_rx_udf <= 1'b0;
    end else begin
      r_tx_ovf <= w_tx_drop | (r_tx_ovf & ~w_stat_rd);
      r_rx_udf <= w_rx_miss | (r_rx_udf & ~w_stat_rd);
    end
  end

  assign w_tx_ovf = r_tx_ovf;
  assign w_rx_udf = r_rx_udf;
`else
  assign w_tx_ovf = 1'b0;
  assign w_rx_udf = 1'b0;
`endif

  always_comb begin
    w_status          = '0;
    w_status.tx_full  = w_tx_full;
    w_status.tx_empty = w_tx_empty;
    w_status.rx_full  = w_rx_full;
    w_status.rx_empty = w_rx_empty;
    w_status.tx_count = sat_cnt(w_tx_count);
    w_status.rx_count = sat_cnt(w_rx_count);
    w_status.tx_ovf   = w_tx_ovf;
    w_status.rx_udf   = w_rx_udf;
  end

  always_comb begin
    w_rdata = '0;
    if (w_rd) begin
      case (w_sel)
        IO_ADDR_RX:     w_rdata = w_rx_head;
        IO_ADDR_STATUS: w_rdata = w_status;
        default:        w_rdata = '0;
      endcase
    end
  end

  assign bus.data_out = w_rdata;

endmodule

// File: tb/tb_io_responder.sv
// Scoreboard bench for io_responder: TX/RX queues model the FIFOs and are
// checked every cycle, plus directed checks from the stimulus sequence.
module tb_io_responder;
  import io_responder_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  io_responder_if bus();

  io_responder #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] tx_q[$];
  logic [15:0] rx_q[$];
  logic        m_ovf = 1'b0;
  logic        m_udf = 1'b0;
  int          m_ntx;
  int          m_nrx;
  logic [15:0] m_exp;

  logic        g_txr = 1'b0;
  logic        g_rxv = 1'b0;
  logic [15:0] g_rxd = '0;
  logic [15:0] rd;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] mstat();
    logic [15:0] s;
    s = '0;
    s[ST_TX_FULL]  = (tx_q.size() == DEPTH);
    s[ST_TX_EMPTY] = (tx_q.size() == 0);
    s[ST_RX_FULL]  = (rx_q.size() == DEPTH);
    s[ST_RX_EMPTY] = (rx_q.size() == 0);
    s[ST_TX_CNT_LO +: 3] = 3'(tx_q.size());
    s[ST_RX_CNT_LO +: 3] = 3'(rx_q.size());
`ifdef IORESP_ERR_FLAGS_EN
    s[ST_TX_OVF] = m_ovf;
    s[ST_RX_UDF] = m_udf;
`endif
    return s;
  endfunction

  // Reference model: compare against pre-edge state, then apply this cycle's commits.
  always @(negedge clk) begin
    if (!rst_n) begin
      tx_q.delete();
      rx_q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      m_ntx = tx_q.size();
      m_nrx = rx_q.size();
      check("tx_valid", 16'(bus.tx_valid_out), 16'(m_ntx != 0));
      if (m_ntx != 0) check("tx_data", bus.tx_data_out, tx_q[0]);
      else            check("tx_data_idle", bus.tx_data_out, 16'h0000);
      check("rx_ready", 16'(bus.rx_ready_out), 16'(m_nrx < DEPTH));
      m_exp = '0;
      if (bus.iom_in && bus.wen_in) begin
        if (bus.addr_in[1:0] == IO_ADDR_RX && m_nrx != 0) m_exp = rx_q[0];
        else if (bus.addr_in[1:0] == IO_ADDR_STATUS)      m_exp = mstat();
      end
      check("data_out", bus.data_out, m_exp);

      if (bus.iom_in && bus.wen_in && bus.addr_in[1:0] == IO_ADDR_STATUS) begin
        m_ovf = 1'b0;
        m_udf = 1'b0;
      end
      if (bus.tx_ready_in && m_ntx != 0) void'(tx_q.pop_front());
      if (bus.iom_in && !bus.wen_in && bus.addr_in[1:0] == IO_ADDR_TX) begin
        if (m_ntx < DEPTH) tx_q.push_back(bus.data_in);
        else               m_ovf = 1'b1;
      end
      if (bus.iom_in && bus.wen_in && bus.addr_in[1:0] == IO_ADDR_RX) begin
        if (m_nrx != 0) void'(rx_q.pop_front());
        else            m_udf = 1'b1;
      end
      if (bus.rx_valid_in && m_nrx < DEPTH) rx_q.push_back(bus.rx_data_in);
    end
  end

  task automatic cyc(input logic iom, input logic wen, input logic [15:0] addr,
                     input logic [15:0] wd, output logic [15:0] rdata);
    @(posedge clk);
    #1;
    bus.iom_in      = iom;
    bus.wen_in      = wen;
    bus.addr_in     = addr;
    bus.data_in     = wd;
    bus.tx_ready_in = g_txr;
    bus.rx_valid_in = g_rxv;
    bus.rx_data_in  = g_rxd;
    @(negedge clk);
    rdata = bus.data_out;
  endtask

  task automatic io_wr(input logic [15:0] addr, input logic [15:0] wd);
    logic [15:0] junk;
    cyc(1'b1, 1'b0, addr, wd, junk);
  endtask

  task automatic io_rd(input logic [15:0] addr, output logic [15:0] rdata);
    cyc(1'b1, 1'b1, addr, 16'h0000, rdata);
  endtask

  task automatic idle();
    logic [15:0] junk;
    cyc(1'b0, 1'b1, 16'h0000, 16'h0000, junk);
  endtask

  initial begin
    bus.iom_in = 1'b0; bus.wen_in = 1'b1; bus.addr_in = '0; bus.data_in = '0;
    bus.tx_ready_in = 1'b0; bus.rx_valid_in = 1'b0; bus.rx_data_in = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    idle();
    check("rst_tx_valid", 16'(bus.tx_valid_out), 16'h0000);
    check("rst_tx_data", bus.tx_data_out, 16'h0000);
    check("rst_rx_ready", 16'(bus.rx_ready_out), 16'h0001);
    io_rd(16'(IO_ADDR_STATUS), rd);
    check("rst_status", rd, 16'h000A);

    // TX ordering with backpressure
    io_wr(16'h0000, 16'h1234);
    io_wr(16'h0000, 16'hBEEF);
    idle();
    check("tx_hold_valid", 16'(bus.tx_valid_out), 16'h0001);
    check("tx_hold_data", bus.tx_data_out, 16'h1234);
    g_txr = 1'b1;
    idle();
    idle();
    check("tx_second", bus.tx_data_out, 16'hBEEF);
    idle();
    check("tx_drained", 16'(bus.tx_valid_out), 16'h0000);
    g_txr = 1'b0;

    // RX fill then read back
    for (int i = 1; i <= 4; i++) begin
      g_rxv = 1'b1;
      g_rxd = 16'(i);
      idle();
    end
    g_rxv = 1'b0;
    idle();
    check("rx_full_ready", 16'(bus.rx_ready_out), 16'h0000);
    io_rd(16'(IO_ADDR_STATUS), rd);
    check("rx_full_bit", 16'(rd[ST_RX_FULL]), 16'h0001);
    for (int i = 1; i <= 4; i++) begin
      io_rd(16'(IO_ADDR_RX), rd);
      check("rx_pop", rd, 16'(i));
    end
    io_rd(16'(IO_ADDR_STATUS), rd);
    check("rx_empty_bit", 16'(rd[ST_RX_EMPTY]), 16'h0001);

    // TX overflow, then overflow with a same-cycle pop
    for (int i = 0; i < 5; i++) io_wr(16'h0000, 16'h0010 + 16'(i));
    io_rd(16'(IO_ADDR_STATUS), rd);
`ifdef IORESP_ERR_FLAGS_EN
    check("ovf_status", rd, 16'h0449);
`else
    check("ovf_status", rd, 16'h0049);
`endif
    io_rd(16'(IO_ADDR_STATUS), rd);
    check("ovf_cleared", rd, 16'h0049);
    g_txr = 1'b1;
    io_wr(16'h0000, 16'h00EE);
    g_txr = 1'b0;
    io_rd(16'(IO_ADDR_STATUS), rd);
`ifdef IORESP_ERR_FLAGS_EN
    check("ovf_pop_status", rd, 16'h0438);
`else
    check("ovf_pop_status", rd, 16'h0038);
`endif
    g_txr = 1'b1;
    repeat (5) idle();
    g_txr = 1'b0;
    check("ovf_drained", 16'(bus.tx_valid_out), 16'h0000);

    // Empty RX read racing an RX push
    g_rxv = 1'b1;
    g_rxd = 16'hABCD;
    io_rd(16'(IO_ADDR_RX), rd);
    check("udf_read", rd, 16'h0000);
    g_rxv = 1'b0;
    io_rd(16'(IO_ADDR_RX), rd);
    check("udf_next", rd, 16'hABCD);
    io_rd(16'(IO_ADDR_STATUS), rd);
`ifdef IORESP_ERR_FLAGS_EN
    check("udf_status", rd, 16'h080A);
`else
    check("udf_status", rd, 16'h000A);
`endif

    // Address aliasing and ignored/reserved slots
    io_wr(16'hFFFC, 16'h5A5A);
    io_wr(16'h0002, 16'h1111);
    io_wr(16'h0001, 16'h2222);
    io_rd(16'h0003, rd);
    check("rsvd_read", rd, 16'h0000);
    io_rd(16'h0000, rd);
    check("tx_addr_read", rd, 16'h0000);
    check("alias_data", bus.tx_data_out, 16'h5A5A);
    io_wr(16'h0000, 16'h7777);

    // Reset during a simultaneous TX pop and IOW
    @(posedge clk);
    #1;
    bus.iom_in = 1'b1; bus.wen_in = 1'b0; bus.addr_in = 16'h0000; bus.data_in = 16'h8888;
    bus.tx_ready_in = 1'b1;
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    bus.iom_in = 1'b0; bus.wen_in = 1'b1; bus.tx_ready_in = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle();
    check("rst2_tx_valid", 16'(bus.tx_valid_out), 16'h0000);
    check("rst2_rx_ready", 16'(bus.rx_ready_out), 16'h0001);
    io_rd(16'(IO_ADDR_STATUS), rd);
    check("rst2_status", rd, 16'h000A);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
